// File: rtl/nand_core_param.sv
// rtl/nand_core_param.sv - parametrised single-issue NAND/branch core with handshaked program load
// Flat register map: 0 = constant 1, then inputs, then outputs, then internal bits.
module nand_core_param #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 7,
  parameter int PC_W       = 10,
  parameter int IMEM_DEPTH = 1000,
  localparam int INSTR_W   = 1 + 3*REG_ADDR_W,
  localparam int OFF_W     = 2*REG_ADDR_W - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic [NUM_IN-1:0]  in_reg,
  output logic [NUM_OUT-1:0] out_reg,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         state,
  output logic               fault,
  output logic [PC_W:0]      load_count
);

  localparam int NREG     = 2**REG_ADDR_W;
  localparam int IMEM_AW  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3} state_t;

  state_t                   st;
  logic [PC_W-1:0]          pc_r;
  logic                     fault_r;
  logic [PC_W:0]            ptr;
  logic [NREG-1:NUM_IN+1]   regs;
  logic [INSTR_W-1:0]       imem [IMEM_DEPTH];

  logic [INSTR_W-1:0]       instr;
  logic [NREG-1:0]          view;
  logic                     op;
  logic [REG_ADDR_W-1:0]    a_addr, b_addr, d_addr;
  logic                     dir;
  logic [OFF_W-1:0]         mag;
  logic [PC_W-1:0]          mag_ext;
  logic                     va, vb, vc;
  logic                     d_writable;
  logic                     fetch_oob;
  logic                     accept;

  assign instr      = imem[pc_r[IMEM_AW-1:0]];
  assign view       = {regs, in_reg, 1'b1};
  assign op         = instr[0];
  assign a_addr     = instr[REG_ADDR_W:1];
  assign b_addr     = instr[2*REG_ADDR_W:REG_ADDR_W+1];
  assign d_addr     = instr[3*REG_ADDR_W:2*REG_ADDR_W+1];
  assign dir        = instr[REG_ADDR_W+1];
  assign mag        = instr[INSTR_W-1:REG_ADDR_W+2];
  assign mag_ext    = PC_W'(mag);
  // branch condition register shares the A field
  assign va         = view[a_addr];
  assign vb         = view[b_addr];
  assign vc         = va;
  assign d_writable = d_addr > REG_ADDR_W'(NUM_IN);
  assign fetch_oob  = {1'b0, pc_r} >= load_count;

  assign load_ready = (st == S_LOAD) && (ptr < (PC_W+1)'(IMEM_DEPTH));
  assign accept     = load_ready && load_valid;

  assign out_reg    = regs[NUM_IN+NUM_OUT:NUM_IN+1];
  assign pc         = pc_r;
  assign state      = st;
  assign fault      = fault_r;

  always_ff @(posedge clk) begin
    if (accept) imem[ptr[IMEM_AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      pc_r       <= '0;
      fault_r    <= 1'b0;
      ptr        <= '0;
      regs       <= '0;
      load_count <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (load_en) begin
            st  <= S_LOAD;
            ptr <= '0;
          end else if (start && load_count != '0) begin
            st   <= S_RUN;
            pc_r <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ptr        <= ptr + 1'b1;
            load_count <= ptr + 1'b1;
          end
          if (!load_en) st <= S_IDLE;
        end
        S_RUN: begin
          if (load_en) begin
            st  <= S_LOAD;
            ptr <= '0;
          end else if (fetch_oob) begin
            st      <= S_HALT;
            fault_r <= 1'b1;
          end else if (op) begin
            if (d_writable) regs[d_addr] <= ~(va & vb);
            pc_r <= pc_r + 1'b1;
          end else if (vc) begin
            // a taken zero-offset branch can never leave itself, so stop cleanly
            if (mag == '0) st <= S_HALT;
            else           pc_r <= dir ? (pc_r - mag_ext) : (pc_r + mag_ext);
          end else begin
            pc_r <= pc_r + 1'b1;
          end
        end
        S_HALT: begin
          if (load_en) begin
            st      <= S_LOAD;
            ptr     <= '0;
            fault_r <= 1'b0;
          end else if (start) begin
            st      <= S_RUN;
            pc_r    <= '0;
            fault_r <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_core_param.sv
// tb/tb_nand_core_param.sv - directed self-checking bench for nand_core_param
module tb_nand_core_param;

  localparam int INSTR_W = 13;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               load_en = 1'b0;
  logic               load_valid = 1'b0;
  logic [INSTR_W-1:0] load_data = '0;
  logic               load_ready;
  logic               start = 1'b0;
  logic [1:0]         in_reg = 2'b00;
  logic [6:0]         out_reg;
  logic [9:0]         pc;
  logic [1:0]         state;
  logic               fault;
  logic [10:0]        load_count;

  int passed = 0;
  int total  = 0;
  int acc;

  nand_core_param #(
    .REG_ADDR_W(4), .NUM_IN(2), .NUM_OUT(7), .PC_W(10), .IMEM_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .in_reg(in_reg), .out_reg(out_reg),
    .pc(pc), .state(state), .fault(fault), .load_count(load_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] nand_w(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    return {d, b, a, 1'b1};
  endfunction

  function automatic logic [12:0] br_w(input logic [3:0] c, input logic dir, input logic [6:0] m);
    return {m, dir, c, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [12:0] w0, input logic [12:0] w1,
                           input logic [12:0] w2, input logic [12:0] w3, input int n);
    logic [12:0] words [4];
    int budget;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    load_en = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      budget = 20;
      while (!load_ready && budget > 0) begin
        step();
        budget--;
      end
      if (budget == 0) chk("load_ready_timeout", 32'(load_ready), 32'd1);
      step();
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_out", 32'(out_reg), 32'd0);
    #10 reset = 1'b1;
    step();

    // T1 toggle loop
    load_prog(nand_w(4'd1, 4'd0, 4'd3), br_w(4'd0, 1'b1, 7'd1), '0, '0, 2);
    chk("t1_count", 32'(load_count), 32'd2);
    in_reg = 2'b01;
    pulse_start();
    chk("t1_run", 32'(state), 32'd2);
    chk("t1_pc0", 32'(pc), 32'd0);
    step();
    chk("t1_out_lo", 32'(out_reg), 32'h00);
    chk("t1_pc1", 32'(pc), 32'd1);
    step();
    chk("t1_br_back", 32'(pc), 32'd0);
    in_reg = 2'b00;
    step();
    chk("t1_out_hi", 32'(out_reg), 32'h01);

    // T6 async reset mid-run
    #3 reset = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_out", 32'(out_reg), 32'd0);
    chk("t6_count", 32'(load_count), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    #3 reset = 1'b1;
    step();
    pulse_start();
    step();
    chk("t6_start_ignored", 32'(state), 32'd0);

    // T2 self-loop halt
    load_prog(br_w(4'd0, 1'b0, 7'd0), '0, '0, '0, 1);
    chk("t2_count", 32'(load_count), 32'd1);
    pulse_start();
    step();
    chk("t2_state", 32'(state), 32'd3);
    chk("t2_pc", 32'(pc), 32'd0);
    chk("t2_fault", 32'(fault), 32'd0);
    chk("t2_out", 32'(out_reg), 32'd0);

    // T3 run off the end of the program
    in_reg = 2'b00;
    load_prog(nand_w(4'd1, 4'd1, 4'd4), '0, '0, '0, 1);
    chk("t3_state_idle", 32'(state), 32'd0);
    pulse_start();
    step();
    chk("t3_out", 32'(out_reg), 32'h02);
    chk("t3_pc1", 32'(pc), 32'd1);
    step();
    chk("t3_state", 32'(state), 32'd3);
    chk("t3_fault", 32'(fault), 32'd1);
    chk("t3_pc", 32'(pc), 32'd1);

    // T5 writes to constant and input addresses are dropped
    in_reg = 2'b01;
    load_prog(nand_w(4'd0, 4'd0, 4'd0), nand_w(4'd0, 4'd0, 4'd1), nand_w(4'd1, 4'd0, 4'd5), '0, 3);
    chk("t5_fault_clr", 32'(fault), 32'd0);
    pulse_start();
    step();
    chk("t5_pc1", 32'(pc), 32'd1);
    chk("t5_out1", 32'(out_reg), 32'h02);
    step();
    chk("t5_pc2", 32'(pc), 32'd2);
    step();
    chk("t5_pc3", 32'(pc), 32'd3);
    chk("t5_out3", 32'(out_reg), 32'h02);
    step();
    chk("t5_halt", 32'(state), 32'd3);

    // T4 imem full: six words offered, four accepted
    load_en = 1'b1;
    step();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = nand_w(4'd0, 4'd0, 4'd10);
      if (load_ready) acc++;
      step();
    end
    chk("t4_accepted", 32'(acc), 32'd4);
    chk("t4_ready", 32'(load_ready), 32'd0);
    chk("t4_count", 32'(load_count), 32'd4);
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    chk("t4_idle", 32'(state), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk("t4_pc4", 32'(pc), 32'd4);
    chk("t4_running", 32'(state), 32'd2);
    step();
    chk("t4_fault", 32'(fault), 32'd1);

    // forward branch, untaken branch, then self-loop halt
    in_reg = 2'b00;
    load_prog(br_w(4'd0, 1'b0, 7'd2), nand_w(4'd0, 4'd0, 4'd3),
              br_w(4'd1, 1'b0, 7'd5), br_w(4'd0, 1'b0, 7'd0), 4);
    pulse_start();
    step();
    chk("t7_fwd", 32'(pc), 32'd2);
    step();
    chk("t7_not_taken", 32'(pc), 32'd3);
    step();
    chk("t7_halt", 32'(state), 32'd3);
    chk("t7_pc", 32'(pc), 32'd3);
    chk("t7_out", 32'(out_reg), 32'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
